// File: rtl/core_pkg.sv
// core_pkg: core-wide widths shared by the memory path.
//   Xlen           data/address width
//   MaskBits       byte-enable width (Xlen/8)
//   MemRespLatency default accept-to-response latency of mem_responder
//   mem_resp_t     one stage of the mem_responder response delay line
// Optional macro MEM_RESPONDER_ADDR_CHECK_EN adds an err bit to mem_resp_t.
package core_pkg;

  localparam int Xlen           = 64;
  localparam int MaskBits       = Xlen / 8;
  localparam int MemRespLatency = 1;

  typedef struct packed {
    logic            valid;
`ifdef MEM_RESPONDER_ADDR_CHECK_EN
    logic            err;
`endif
    logic [Xlen-1:0] rdata;
  } mem_resp_t;

endpackage

// File: rtl/mem_bytewrite_ram.sv
// mem_bytewrite_ram: Depth x Width synchronous word array.
// Per-byte write enables; the read is taken on the clock edge into a
// registered output that holds zero on any edge without a read, so the
// output is only non-zero in the cycle right after a read.
// Ports:
//   clk    clock
//   rst_n  async active-low reset, clears the read register only
//   be     byte write enables (any set bit writes that byte)
//   addr   word index
//   wdata  write data
//   re     read enable
//   rdata  registered read data
module mem_bytewrite_ram #(
  parameter int Width = 64,
  parameter int Depth = 1024
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [Width/8-1:0]       be,
  input  logic [$clog2(Depth)-1:0] addr,
  input  logic [Width-1:0]         wdata,
  input  logic                     re,
  output logic [Width-1:0]         rdata
);

  localparam int Bytes = Width / 8;

  logic [Width-1:0] mem [Depth];

  always_ff @(posedge clk) begin
    for (int i = 0; i < Bytes; i++) begin
      if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= mem[addr];
    else         rdata <= '0;
  end

endmodule

// File: rtl/mem_responder.sv
// mem_responder: responder end of the data-memory request bus.
// One request per valid/ready handshake; byte-masked writes into an internal
// array; exactly one mem_rvalid_o pulse per accepted request, Latency cycles
// after the accepting edge, in order, with no response backpressure.
// Ports:
//   clk_i         clock
//   rst_ni        async active-low reset
//   mem_valid_i   request valid
//   mem_ready_o   registered ready, (outstanding < MaxOutstanding)
//   mem_addr_i    byte address; only the word-index bits are decoded
//   mem_wdata_i   lane-shifted write data
//   mem_wmask_i   byte enables, all-zero means load
//   mem_rdata_o   full aligned word for loads, zero otherwise
//   mem_rvalid_o  single-cycle response pulse
//   mem_err_o     (MEM_RESPONDER_ADDR_CHECK_EN only) out-of-range address
// Macro MEM_RESPONDER_ADDR_CHECK_EN: flag requests with address bits above
// the array range instead of aliasing them; their writes are dropped.
module mem_responder #(
  parameter int Xlen           = core_pkg::Xlen,
  parameter int MaskBits       = core_pkg::MaskBits,
  parameter int Depth          = 1024,
  parameter int Latency        = core_pkg::MemRespLatency,
  parameter int MaxOutstanding = 2
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                mem_valid_i,
  output logic                mem_ready_o,
  input  logic [Xlen-1:0]     mem_addr_i,
  input  logic [Xlen-1:0]     mem_wdata_i,
  input  logic [MaskBits-1:0] mem_wmask_i,
  output logic [Xlen-1:0]     mem_rdata_o,
  output logic                mem_rvalid_o
`ifdef MEM_RESPONDER_ADDR_CHECK_EN
  ,
  output logic                mem_err_o
`endif
);

  import core_pkg::*;

  localparam int OffW = $clog2(MaskBits);
  localparam int IdxW = $clog2(Depth);
  localparam int CntW = $clog2(MaxOutstanding + 1);
  localparam logic [CntW-1:0] MaxCnt = CntW'(MaxOutstanding);

  logic                accept;
  logic                is_load;
  logic                addr_err;
  logic [IdxW-1:0]     idx;
  logic [MaskBits-1:0] wr_be;
  logic [Xlen-1:0]     ram_rdata;
  logic                head_valid_q;
  logic [CntW-1:0]     count_q;
  logic [CntW-1:0]     count_next;
  logic                ready_q;
  mem_resp_t           head;
  mem_resp_t           resp_out;

  assign accept  = mem_valid_i && ready_q;
  assign is_load = (mem_wmask_i == '0);
  assign idx     = mem_addr_i[OffW +: IdxW];

`ifdef MEM_RESPONDER_ADDR_CHECK_EN
  logic head_err_q;
  logic unused_addr;
  assign addr_err    = |mem_addr_i[Xlen-1:OffW+IdxW];
  assign unused_addr = ^mem_addr_i[OffW-1:0];
`else
  // Upper address bits alias onto the array.
  logic unused_addr;
  assign addr_err    = 1'b0;
  assign unused_addr = ^{mem_addr_i[Xlen-1:OffW+IdxW], mem_addr_i[OffW-1:0]};
`endif

  assign wr_be = (accept && !addr_err) ? mem_wmask_i : '0;

  mem_bytewrite_ram #(
    .Width (Xlen),
    .Depth (Depth)
  ) u_ram (
    .clk   (clk_i),
    .rst_n (rst_ni),
    .be    (wr_be),
    .addr  (idx),
    .wdata (mem_wdata_i),
    .re    (accept && is_load && !addr_err),
    .rdata (ram_rdata)
  );

  // First delay-line stage: the RAM read register already holds the data
  // (zero for stores and idle edges), so only the flags are registered here.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_valid_q <= 1'b0;
`ifdef MEM_RESPONDER_ADDR_CHECK_EN
      head_err_q   <= 1'b0;
`endif
    end else begin
      head_valid_q <= accept;
`ifdef MEM_RESPONDER_ADDR_CHECK_EN
      head_err_q   <= accept && addr_err;
`endif
    end
  end

  always_comb begin
    head       = '0;
    head.valid = head_valid_q;
    head.rdata = ram_rdata;
`ifdef MEM_RESPONDER_ADDR_CHECK_EN
    head.err   = head_err_q;
`endif
  end

  if (Latency == 1) begin : g_direct
    assign resp_out = head;
  end else begin : g_line
    mem_resp_t line_q [Latency-1];

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        for (int i = 0; i < Latency-1; i++) line_q[i] <= '0;
      end else begin
        line_q[0] <= head;
        for (int i = 1; i < Latency-1; i++) line_q[i] <= line_q[i-1];
      end
    end

    assign resp_out = line_q[Latency-2];
  end

  // A response leaves the count on the edge that ends its rvalid cycle.
  always_comb begin
    count_next = count_q;
    if (accept && !resp_out.valid)      count_next = count_q + CntW'(1);
    else if (!accept && resp_out.valid) count_next = count_q - CntW'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
      ready_q <= 1'b0;
    end else begin
      count_q <= count_next;
      ready_q <= (count_next < MaxCnt);
    end
  end

  assign mem_ready_o  = ready_q;
  assign mem_rvalid_o = resp_out.valid;
  assign mem_rdata_o  = resp_out.rdata;
`ifdef MEM_RESPONDER_ADDR_CHECK_EN
  assign mem_err_o    = resp_out.err;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: three mem_responder instances
//   i0: Latency=1 MaxOutstanding=2
//   i1: Latency=3 MaxOutstanding=2
//   i2: Latency=3 MaxOutstanding=4
// A transaction-level model (word array, response queue with due times,
// outstanding count) predicts ready/rvalid/rdata every cycle; directed
// sequences add literal expectations; a random phase follows.
module tb_mem_responder;

  localparam int NI = 3;
  localparam int LatTab [NI] = '{1, 3, 3};
  localparam int MaxTab [NI] = '{2, 2, 4};

  typedef struct {
    int          due;
    logic [63:0] data;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        v   [NI];
  logic [63:0] a   [NI];
  logic [63:0] wd  [NI];
  logic [7:0]  wm  [NI];
  logic        rdy [NI];
  logic        rv  [NI];
  logic [63:0] rd  [NI];
  logic        err [NI];

  // model state
  exp_t        q      [NI][$];
  logic [63:0] mem_m  [NI][1024];
  int          e      [NI];
  int          cnt    [NI];
  logic        acc    [NI];
  logic        rdy_e  [NI];
  logic        rv_e   [NI];
  logic [63:0] rd_e   [NI];
  logic        err_e  [NI];
  int          rvc    [NI];

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_inst
    mem_responder #(
      .Depth          (1024),
      .Latency        (LatTab[g]),
      .MaxOutstanding (MaxTab[g])
    ) u_dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .mem_valid_i  (v[g]),
      .mem_ready_o  (rdy[g]),
      .mem_addr_i   (a[g]),
      .mem_wdata_i  (wd[g]),
      .mem_wmask_i  (wm[g]),
      .mem_rdata_o  (rd[g]),
      .mem_rvalid_o (rv[g])
`ifdef MEM_RESPONDER_ADDR_CHECK_EN
      ,
      .mem_err_o    (err[g])
`endif
    );
`ifndef MEM_RESPONDER_ADDR_CHECK_EN
    assign err[g] = 1'b0;
`endif
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] pat(input int w);
    return 64'h0123_4567_89AB_CDEF ^ (64'(w) * 64'h0000_1111_0000_1111);
  endfunction

  // Behavioural model: steps once per clock edge on request-level rules.
  initial begin
    for (int g = 0; g < NI; g++) begin
      cnt[g] = 0; e[g] = 0; acc[g] = 0; rdy_e[g] = 0;
      rv_e[g] = 0; rd_e[g] = '0; err_e[g] = 0;
    end
    forever begin
      @(posedge clk or negedge rst_n);
      for (int g = 0; g < NI; g++) begin
        if (!rst_n) begin
          q[g].delete();
          cnt[g] = 0; acc[g] = 0; rdy_e[g] = 0;
          rv_e[g] = 0; rd_e[g] = '0; err_e[g] = 0;
        end else begin
          exp_t r;
          int   widx;
          logic bad;
          e[g]++;
          acc[g] = v[g] && rdy_e[g];
          if (acc[g]) begin
            widx = int'((a[g] >> 3) % 64'd1024);
            bad  = 1'b0;
`ifdef MEM_RESPONDER_ADDR_CHECK_EN
            bad  = (a[g] >= 64'h2000);
`endif
            r.due  = e[g] + LatTab[g] - 1;
            r.data = '0;
            r.err  = bad;
            if (wm[g] == 8'h00) begin
              if (!bad) r.data = mem_m[g][widx];
            end else if (!bad) begin
              for (int b = 0; b < 8; b++)
                if (wm[g][b]) mem_m[g][widx][8*b +: 8] = wd[g][8*b +: 8];
            end
            q[g].push_back(r);
          end
          cnt[g] = cnt[g] + int'(acc[g]) - int'(rv_e[g]);
          rdy_e[g] = (cnt[g] < MaxTab[g]);
          if (q[g].size() > 0 && q[g][0].due == e[g]) begin
            rv_e[g] = 1'b1; rd_e[g] = q[g][0].data; err_e[g] = q[g][0].err;
            void'(q[g].pop_front());
          end else begin
            rv_e[g] = 1'b0; rd_e[g] = '0; err_e[g] = 1'b0;
          end
        end
      end
    end
  end

  // Compare process: every cycle, away from the active edge.
  initial forever begin
    @(negedge clk);
    for (int g = 0; g < NI; g++) begin
      chk($sformatf("i%0d_ready", g), 64'(rdy[g]), 64'(rdy_e[g]));
      chk($sformatf("i%0d_rvalid", g), 64'(rv[g]), 64'(rv_e[g]));
      chk($sformatf("i%0d_rdata", g), rd[g], rd_e[g]);
`ifdef MEM_RESPONDER_ADDR_CHECK_EN
      chk($sformatf("i%0d_err", g), 64'(err[g]), 64'(err_e[g]));
`endif
    end
  end

  initial forever begin
    @(posedge clk);
    cyc++;
    for (int g = 0; g < NI; g++) if (rv[g]) rvc[g]++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic req(input int g, input logic [63:0] addr, input logic [63:0] wdata,
                     input logic [7:0] mask);
    int n = 0;
    v[g] = 1'b1; a[g] = addr; wd[g] = wdata; wm[g] = mask;
    do begin
      @(posedge clk); #1; n++;
    end while (!acc[g] && n < 50);
    chk($sformatf("i%0d_accept", g), 64'(acc[g]), 64'd1);
    v[g] = 1'b0;
  endtask

  task automatic load_chk(input int g, input logic [63:0] addr, input logic [63:0] exp,
                          input string name);
    int n = 0;
    req(g, addr, '0, 8'h00);
    while (!rv[g] && n < 10) begin
      @(posedge clk); #1; n++;
    end
    chk({name, "_rvalid"}, 64'(rv[g]), 64'd1);
    chk(name, rd[g], exp);
  endtask

  task automatic idle(input int k);
    repeat (k) begin @(posedge clk); #1; end
  endtask

  task automatic rand_run(input int g, input int nreq);
    logic [63:0] ad;
    logic [7:0]  m;
    for (int k = 0; k < nreq; k++) begin
      ad = {$urandom, $urandom};
`ifdef MEM_RESPONDER_ADDR_CHECK_EN
      if ($urandom_range(0, 7) != 0) ad = ad & 64'h1FFF;
`endif
      ad = (ad & ~64'h1FF8) | (64'($urandom_range(0, 7)) << 3);
      m  = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
      req(g, ad, {$urandom, $urandom}, m);
      idle($urandom_range(0, 2));
    end
  endtask

  initial begin
    int c0, r0;
    for (int g = 0; g < NI; g++) begin
      v[g] = 1'b0; a[g] = '0; wd[g] = '0; wm[g] = '0; rvc[g] = 0;
    end
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int g = 0; g < NI; g++) begin
      chk($sformatf("i%0d_reset_ready", g), 64'(rdy[g]), 64'd0);
      chk($sformatf("i%0d_reset_rvalid", g), 64'(rv[g]), 64'd0);
      chk($sformatf("i%0d_reset_rdata", g), rd[g], 64'd0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int g = 0; g < NI; g++) chk($sformatf("i%0d_ready_after_reset", g), 64'(rdy[g]), 64'd1);

    for (int g = 0; g < NI; g++)
      for (int w = 0; w < 8; w++) req(g, 64'(w * 8), pat(w), 8'hFF);
    idle(5);

    // Latency=1 store then load
    req(0, 64'h10, 64'h1122_3344_5566_7788, 8'hFF);
    chk("l1_store_rvalid", 64'(rv[0]), 64'd1);
    chk("l1_store_rdata", rd[0], 64'd0);
    load_chk(0, 64'h10, 64'h1122_3344_5566_7788, "l1_load");
    req(0, 64'h13, 64'h0000_0000_AB00_0000, 8'h08);
    load_chk(0, 64'h10, 64'h1122_3344_AB66_7788, "byte_mask_load");
    idle(3);

    // Same-edge accept and rvalid keep ready high at Latency=1
    for (int k = 0; k < 3; k++) begin
      req(0, 64'h18, '0, 8'h00);
      chk("l1_b2b_ready", 64'(rdy[0]), 64'd1);
    end
    idle(5);

    // Latency=3, MaxOutstanding=2: four loads with valid held
    c0 = cyc; r0 = rvc[1];
    req(1, 64'h00, '0, 8'h00);
    req(1, 64'h08, '0, 8'h00);
    chk("l3_ready_full", 64'(rdy[1]), 64'd0);
    req(1, 64'h10, '0, 8'h00);
    req(1, 64'h18, '0, 8'h00);
    chk("l3_four_loads_edges", 64'(cyc - c0), 64'd6);
    idle(6);
    chk("l3_rvalid_count", 64'(rvc[1] - r0), 64'd4);

    // MaxOutstanding=Latency+1: 100 back-to-back, zero stalls
    c0 = cyc; r0 = rvc[2];
    for (int k = 0; k < 100; k++)
      req(2, 64'($urandom_range(0, 7) * 8), {$urandom, $urandom},
          ($urandom_range(0, 1) == 0) ? 8'h00 : 8'hFF);
    chk("b2b_edges", 64'(cyc - c0), 64'd100);
    idle(6);
    chk("b2b_rvalid_count", 64'(rvc[2] - r0), 64'd100);

    // Reset with two responses in flight
    req(1, 64'h00, '0, 8'h00);
    req(1, 64'h08, '0, 8'h00);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_rvalid", 64'(rv[1]), 64'd0);
    chk("midrst_ready", 64'(rdy[1]), 64'd0);
    chk("midrst_rdata", rd[1], 64'd0);
    r0 = rvc[1];
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_ready_before_edge", 64'(rdy[1]), 64'd0);
    @(posedge clk); #1;
    chk("midrst_ready_after_edge", 64'(rdy[1]), 64'd1);
    idle(6);
    chk("midrst_no_rvalid", 64'(rvc[1] - r0), 64'd0);
    load_chk(0, 64'h10, 64'h1122_3344_AB66_7788, "store_survives_reset");
    idle(3);

`ifdef MEM_RESPONDER_ADDR_CHECK_EN
    req(0, 64'h2000, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
    chk("oob_err", 64'(err[0]), 64'd1);
    chk("oob_rdata", rd[0], 64'd0);
    load_chk(0, 64'h0, pat(0), "oob_no_corruption");
    idle(3);
`endif

    fork
      rand_run(0, 300);
      rand_run(1, 300);
      rand_run(2, 300);
    join
    idle(10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
